// File: rtl/img_pxl_raster_tagger.sv
// Raster pixel tagger: tags source beats with X/Y coordinates, checks SOF/EOL markers
// and feeds the resizer through a 2-entry skid buffer.
module img_pxl_raster_tagger #(
    parameter int unsigned PXL_PRIM_COLOR_W   = 8,
    parameter int unsigned PXL_PRIM_COLOR_NUM = 3,
    parameter int unsigned IMG_WIDTH_IDX_W    = 11,
    parameter int unsigned IMG_HEIGHT_IDX_W   = 11
) (
    input  logic                                          Clk,
    input  logic                                          Reset,
    input  logic [IMG_WIDTH_IDX_W-1:0]                    CfgWidth,
    input  logic [IMG_HEIGHT_IDX_W-1:0]                   CfgHeight,
    input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] SrcData,
    input  logic                                          SrcSof,
    input  logic                                          SrcEol,
    input  logic                                          SrcVld,
    output logic                                          SrcRdy,
    output logic [PXL_PRIM_COLOR_W-1:0]                   PxlData [PXL_PRIM_COLOR_NUM],
    output logic [IMG_WIDTH_IDX_W-1:0]                    PxlX,
    output logic [IMG_HEIGHT_IDX_W-1:0]                   PxlY,
    output logic [IMG_WIDTH_IDX_W-1:0]                    ImgWidth,
    output logic [IMG_HEIGHT_IDX_W-1:0]                   ImgHeight,
    output logic                                          PxlVld,
    input  logic                                          PxlRdy,
    output logic                                          FrmDone,
    output logic                                          ErrSof,
    output logic                                          ErrEol,
    output logic                                          ErrCfg
);

    localparam int unsigned DW = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic                        last;
        logic [IMG_HEIGHT_IDX_W-1:0] h;
        logic [IMG_WIDTH_IDX_W-1:0]  w;
        logic [IMG_HEIGHT_IDX_W-1:0] y;
        logic [IMG_WIDTH_IDX_W-1:0]  x;
        logic [DW-1:0]               data;
    } entry_t;

    state_t                      state_q, state_d;
    logic [IMG_WIDTH_IDX_W-1:0]  xcnt_q, xcnt_d, w_q, w_d, cur_x, cur_w;
    logic [IMG_HEIGHT_IDX_W-1:0] ycnt_q, ycnt_d, h_q, h_d, cur_y, cur_h;
    entry_t                      e0_q, e0_d, e1_q, e1_d, new_e;
    logic [1:0]                  cnt_q, cnt_d;
    logic                        rdy_q, rdy_d;
    logic                        frm_done_q, err_sof_q, err_sof_d, err_eol_q, err_eol_d, err_cfg_q, err_cfg_d;
    logic                        src_acc, deq, enq, tag, x_last, y_last;

    assign SrcRdy  = rdy_q & ~Reset;
    assign src_acc = SrcVld & SrcRdy;
    assign PxlVld  = (cnt_q != 2'd0);
    assign deq     = PxlVld & PxlRdy;

    // An SOF beat always starts a fresh frame from the live config, whatever the state.
    assign cur_x  = SrcSof ? '0 : xcnt_q;
    assign cur_y  = SrcSof ? '0 : ycnt_q;
    assign cur_w  = SrcSof ? CfgWidth : w_q;
    assign cur_h  = SrcSof ? CfgHeight : h_q;
    assign x_last = (cur_x == cur_w - IMG_WIDTH_IDX_W'(1));
    assign y_last = (cur_y == cur_h - IMG_HEIGHT_IDX_W'(1));

    always_comb begin
        state_d   = state_q;
        xcnt_d    = xcnt_q;
        ycnt_d    = ycnt_q;
        w_d       = w_q;
        h_d       = h_q;
        err_sof_d = 1'b0;
        err_eol_d = 1'b0;
        err_cfg_d = 1'b0;
        tag       = 1'b0;
        enq       = 1'b0;
        new_e     = '0;
        if (src_acc) begin
            if (SrcSof) begin
                err_sof_d = (state_q == ACTIVE);
                if (CfgWidth == '0 || CfgHeight == '0) begin
                    err_cfg_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tag = 1'b1;
                end
            end else if (state_q == IDLE) begin
                err_sof_d = 1'b1;
            end else begin
                tag = 1'b1;
            end
        end
        if (tag) begin
            enq        = 1'b1;
            err_eol_d  = (SrcEol != x_last);
            w_d        = cur_w;
            h_d        = cur_h;
            new_e      = '{last: x_last & y_last, h: cur_h, w: cur_w, y: cur_y, x: cur_x, data: SrcData};
            if (x_last & y_last) begin
                xcnt_d  = '0;
                ycnt_d  = '0;
                state_d = IDLE;
            end else begin
                xcnt_d  = x_last ? '0 : cur_x + IMG_WIDTH_IDX_W'(1);
                ycnt_d  = x_last ? cur_y + IMG_HEIGHT_IDX_W'(1) : cur_y;
                state_d = ACTIVE;
            end
        end
    end

    // Skid buffer: e0 is always the head presented on the output.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        unique case ({enq, deq})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = new_e;
                else               e1_d = new_e;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = new_e;
                end else begin
                    e0_d = e1_q;
                    e1_d = new_e;
                end
            end
            default: ;
        endcase
        rdy_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            xcnt_q     <= '0;
            ycnt_q     <= '0;
            w_q        <= '0;
            h_q        <= '0;
            e0_q       <= '0;
            e1_q       <= '0;
            cnt_q      <= '0;
            rdy_q      <= 1'b1;
            frm_done_q <= 1'b0;
            err_sof_q  <= 1'b0;
            err_eol_q  <= 1'b0;
            err_cfg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            xcnt_q     <= xcnt_d;
            ycnt_q     <= ycnt_d;
            w_q        <= w_d;
            h_q        <= h_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
            frm_done_q <= deq & e0_q.last;
            err_sof_q  <= err_sof_d;
            err_eol_q  <= err_eol_d;
            err_cfg_q  <= err_cfg_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < PXL_PRIM_COLOR_NUM; i++) begin
            PxlData[i] = e0_q.data[i*PXL_PRIM_COLOR_W +: PXL_PRIM_COLOR_W];
        end
    end

    assign PxlX      = e0_q.x;
    assign PxlY      = e0_q.y;
    assign ImgWidth  = e0_q.w;
    assign ImgHeight = e0_q.h;
    assign FrmDone   = frm_done_q;
    assign ErrSof    = err_sof_q;
    assign ErrEol    = err_eol_q;
    assign ErrCfg    = err_cfg_q;

endmodule

// File: tb/tb_img_pxl_raster_tagger.sv
// Directed self-checking bench for img_pxl_raster_tagger: one task per scenario,
// a negedge monitor records output handshakes, pulses and stall stability.
module tb_img_pxl_raster_tagger;

    localparam int CW = 8;
    localparam int CN = 3;
    localparam int WW = 11;
    localparam int HW = 11;
    localparam int DW = CW * CN;

    logic          Clk, Reset;
    logic [WW-1:0] CfgWidth, PxlX, ImgWidth;
    logic [HW-1:0] CfgHeight, PxlY, ImgHeight;
    logic [DW-1:0] SrcData;
    logic          SrcSof, SrcEol, SrcVld, SrcRdy, PxlVld, PxlRdy;
    logic [CW-1:0] PxlData [CN];
    logic          FrmDone, ErrSof, ErrEol, ErrCfg;

    img_pxl_raster_tagger #(
        .PXL_PRIM_COLOR_W  (CW),
        .PXL_PRIM_COLOR_NUM(CN),
        .IMG_WIDTH_IDX_W   (WW),
        .IMG_HEIGHT_IDX_W  (HW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .CfgWidth(CfgWidth), .CfgHeight(CfgHeight),
        .SrcData(SrcData), .SrcSof(SrcSof), .SrcEol(SrcEol), .SrcVld(SrcVld), .SrcRdy(SrcRdy),
        .PxlData(PxlData), .PxlX(PxlX), .PxlY(PxlY), .ImgWidth(ImgWidth), .ImgHeight(ImgHeight),
        .PxlVld(PxlVld), .PxlRdy(PxlRdy), .FrmDone(FrmDone),
        .ErrSof(ErrSof), .ErrEol(ErrEol), .ErrCfg(ErrCfg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [WW-1:0] x;
        logic [HW-1:0] y;
        logic [WW-1:0] w;
        logic [HW-1:0] h;
    } pix_t;

    pix_t got_q[$];
    pix_t exp_q[$];
    int   errors = 0, checks = 0;
    int   frm_cnt = 0, esof_cnt = 0, eeol_cnt = 0, ecfg_cnt = 0, vld_run = 0, max_run = 0;
    pix_t prev;
    logic prev_stall = 1'b0, prev_rst = 1'b1;
    logic rdy_mode = 1'b0;
    int   pi = 0;
    logic rdy_pat [16] = '{1,0,0,1,1,0,1,0,0,1,1,1,0,1,0,0};
    int   bub [7] = '{0,2,1,0,0,2,1};

    always @(negedge Clk) begin
        pix_t cur;
        cur.d = {PxlData[2], PxlData[1], PxlData[0]};
        cur.x = PxlX;
        cur.y = PxlY;
        cur.w = ImgWidth;
        cur.h = ImgHeight;
        if (FrmDone) frm_cnt++;
        if (ErrSof)  esof_cnt++;
        if (ErrEol)  eeol_cnt++;
        if (ErrCfg)  ecfg_cnt++;
        if (prev_stall && !prev_rst) begin
            checks++;
            if (!PxlVld || cur !== prev) begin
                errors++;
                $display("FAIL stall_hold: vld=%0b pix=%h held=%h", PxlVld, cur, prev);
            end
        end
        if (PxlVld && PxlRdy) begin
            got_q.push_back(cur);
            vld_run++;
            if (vld_run > max_run) max_run = vld_run;
        end else begin
            vld_run = 0;
        end
        prev_stall = PxlVld && !PxlRdy;
        prev       = cur;
        prev_rst   = Reset;
    end

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (rdy_mode) begin
                PxlRdy = rdy_pat[pi];
                pi = (pi + 1) % 16;
            end
        end
    end

    task automatic clear();
        got_q.delete();
        exp_q.delete();
        frm_cnt = 0; esof_cnt = 0; eeol_cnt = 0; ecfg_cnt = 0; vld_run = 0; max_run = 0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic sof, input logic eol);
        int t = 0;
        SrcData = d; SrcSof = sof; SrcEol = eol; SrcVld = 1'b1;
        @(negedge Clk);
        while (!SrcRdy && t < 100) begin
            t++;
            @(negedge Clk);
        end
        checks++;
        if (!SrcRdy) begin
            errors++;
            $display("FAIL src_accept: SrcRdy=%0b after %0d cycles, required 1", SrcRdy, t);
        end
        @(posedge Clk);
        #1;
        SrcVld = 1'b0; SrcSof = 1'b0; SrcEol = 1'b0;
    endtask

    // Sends a full frame; eol_x0 places the EOL marker of the first line only.
    task automatic send_frame(input int w, input int h, input int tag, input int eol_x0, input bit bubbles);
        CfgWidth  = WW'(w);
        CfgHeight = HW'(h);
        for (int k = 0; k < w * h; k++) begin
            int   x, y;
            logic eol;
            pix_t e;
            x = k % w;
            y = k / w;
            eol = (k < w) ? (x == eol_x0) : (x == w - 1);
            e.d = {8'(tag), 16'(k)};
            e.x = WW'(x); e.y = HW'(y); e.w = WW'(w); e.h = HW'(h);
            exp_q.push_back(e);
            send(e.d, k == 0, eol);
            if (k == 0) begin
                CfgWidth  = 11'd7;
                CfgHeight = 11'd9;
            end
            if (bubbles) repeat (bub[k % 7]) begin @(posedge Clk); #1; end
        end
    endtask

    task automatic test_reset();
        @(posedge Clk); #1;
        @(negedge Clk);
        checks++;
        if (SrcRdy !== 1'b0 || PxlVld !== 1'b0) begin
            errors++; $display("FAIL reset_rdy_vld: SrcRdy=%0b PxlVld=%0b, required 0 0", SrcRdy, PxlVld);
        end
        checks++;
        if ({FrmDone, ErrSof, ErrEol, ErrCfg} !== 4'b0 || PxlX !== '0 || PxlY !== '0 ||
            ImgWidth !== '0 || ImgHeight !== '0 || PxlData[0] !== '0 || PxlData[2] !== '0) begin
            errors++; $display("FAIL reset_outputs: pulses=%b x=%0d y=%0d w=%0d h=%0d, required all 0",
                               {FrmDone, ErrSof, ErrEol, ErrCfg}, PxlX, PxlY, ImgWidth, ImgHeight);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (SrcRdy !== 1'b1) begin
            errors++; $display("FAIL reset_release_rdy: SrcRdy=%0b, required 1", SrcRdy);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_basic();
        clear();
        send_frame(4, 2, 1, 3, 0);
        drain(10);
        checks++;
        if (got_q.size() != 8) begin
            errors++; $display("FAIL basic_count: got %0d pixels, required 8", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_pix[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (frm_cnt != 1 || esof_cnt + eeol_cnt + ecfg_cnt != 0) begin
            errors++; $display("FAIL basic_pulses: frm=%0d sof=%0d eol=%0d cfg=%0d, required 1 0 0 0",
                               frm_cnt, esof_cnt, eeol_cnt, ecfg_cnt);
        end
        checks++;
        if (max_run != 8) begin
            errors++; $display("FAIL basic_throughput: longest PxlVld run %0d, required 8", max_run);
        end
    endtask

    task automatic test_stall();
        clear();
        rdy_mode = 1'b1;
        send_frame(4, 2, 3, 3, 1);
        drain(40);
        rdy_mode = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        PxlRdy = 1'b1;
        checks++;
        if (got_q.size() != 8) begin
            errors++; $display("FAIL stall_count: got %0d pixels, required 8", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL stall_pix[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (frm_cnt != 1 || esof_cnt + eeol_cnt + ecfg_cnt != 0) begin
            errors++; $display("FAIL stall_pulses: frm=%0d errs=%0d, required 1 0",
                               frm_cnt, esof_cnt + eeol_cnt + ecfg_cnt);
        end
    endtask

    task automatic test_resof();
        clear();
        CfgWidth = 11'd129;
        CfgHeight = 11'd65;
        for (int k = 0; k < 3 * 129 + 5; k++) begin
            pix_t e;
            e.d = {8'd1, 16'(k)};
            e.x = WW'(k % 129); e.y = HW'(k / 129); e.w = 11'd129; e.h = 11'd65;
            exp_q.push_back(e);
            send(e.d, k == 0, (k % 129) == 128);
        end
        send_frame(129, 65, 2, 128, 0);
        drain(10);
        checks++;
        if (got_q.size() != 392 + 8385) begin
            errors++; $display("FAIL resof_count: got %0d pixels, required %0d", got_q.size(), 392 + 8385);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL resof_pix[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (esof_cnt != 1 || frm_cnt != 1 || eeol_cnt != 0 || ecfg_cnt != 0) begin
            errors++; $display("FAIL resof_pulses: sof=%0d frm=%0d eol=%0d cfg=%0d, required 1 1 0 0",
                               esof_cnt, frm_cnt, eeol_cnt, ecfg_cnt);
        end
    endtask

    task automatic test_eol();
        clear();
        send_frame(4, 2, 4, 2, 0);
        drain(10);
        checks++;
        if (got_q.size() != 8) begin
            errors++; $display("FAIL eol_count: got %0d pixels, required 8", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL eol_pix[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (eeol_cnt != 2 || frm_cnt != 1 || esof_cnt != 0) begin
            errors++; $display("FAIL eol_pulses: eol=%0d frm=%0d sof=%0d, required 2 1 0",
                               eeol_cnt, frm_cnt, esof_cnt);
        end
    endtask

    task automatic test_1x1();
        clear();
        send_frame(1, 1, 5, 0, 0);
        drain(5);
        checks++;
        if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
            errors++; $display("FAIL one_pix: got %0d pixels (first %h), required 1 of %h",
                               got_q.size(), got_q.size() ? got_q[0] : '0, exp_q[0]);
        end
        checks++;
        if (frm_cnt != 1 || esof_cnt + eeol_cnt + ecfg_cnt != 0) begin
            errors++; $display("FAIL one_pulses: frm=%0d errs=%0d, required 1 0",
                               frm_cnt, esof_cnt + eeol_cnt + ecfg_cnt);
        end
        clear();
        send(24'h123456, 1'b0, 1'b0);
        @(negedge Clk);
        checks++;
        if (PxlVld !== 1'b0) begin
            errors++; $display("FAIL nosof_vld: PxlVld=%0b, required 0", PxlVld);
        end
        drain(5);
        checks++;
        if (esof_cnt != 1 || got_q.size() != 0 || frm_cnt != 0) begin
            errors++; $display("FAIL nosof_drop: sof=%0d pixels=%0d frm=%0d, required 1 0 0",
                               esof_cnt, got_q.size(), frm_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear();
        PxlRdy = 1'b0;
        CfgWidth = 11'd4;
        CfgHeight = 11'd2;
        send(24'hAA0000, 1'b1, 1'b0);
        send(24'hAA0001, 1'b0, 1'b0);
        @(negedge Clk);
        checks++;
        if (SrcRdy !== 1'b0 || PxlVld !== 1'b1) begin
            errors++; $display("FAIL full_rdy: SrcRdy=%0b PxlVld=%0b, required 0 1", SrcRdy, PxlVld);
        end
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (SrcRdy !== 1'b0) begin
            errors++; $display("FAIL midrst_rdy: SrcRdy=%0b, required 0", SrcRdy);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        PxlRdy = 1'b1;
        @(negedge Clk);
        checks++;
        if (PxlVld !== 1'b0) begin
            errors++; $display("FAIL midrst_vld: PxlVld=%0b, required 0", PxlVld);
        end
        drain(5);
        checks++;
        if (got_q.size() != 0 || frm_cnt != 0) begin
            errors++; $display("FAIL midrst_flush: pixels=%0d frm=%0d, required 0 0", got_q.size(), frm_cnt);
        end
        clear();
        CfgHeight = 11'd0;
        send(24'hBB0000, 1'b1, 1'b1);
        drain(5);
        checks++;
        if (ecfg_cnt != 1 || esof_cnt != 0 || got_q.size() != 0) begin
            errors++; $display("FAIL zero_cfg: cfg=%0d sof=%0d pixels=%0d, required 1 0 0",
                               ecfg_cnt, esof_cnt, got_q.size());
        end
    endtask

    initial begin
        Reset = 1'b1; SrcVld = 1'b0; SrcSof = 1'b0; SrcEol = 1'b0; SrcData = '0;
        CfgWidth = '0; CfgHeight = '0; PxlRdy = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_resof();
        test_eol();
        test_1x1();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/img_pxl_raster_tagger.md
Name: img_pxl_raster_tagger

Overview:
Upstream feeder for the image resizer. Accepts an untagged raster pixel stream with start-of-frame and end-of-line markers from the capture/source side. Latches frame dimensions at start of frame and tags every pixel with its X/Y coordinates. Checks the markers against the counters and drives the resizer's input pixel stream (PxlData/PxlX/PxlY/PxlVld/PxlRdy, ImgWidth/ImgHeight) through a 2-entry skid buffer at full throughput.

Parameters:
PXL_PRIM_COLOR_W, 8, bits per primary colour component
PXL_PRIM_COLOR_NUM, 3, components per pixel
IMG_WIDTH_IDX_W, 11, width of X index and ImgWidth
IMG_HEIGHT_IDX_W, 11, width of Y index and ImgHeight

Ports:
Clk  in  1  clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
CfgWidth  in  IMG_WIDTH_IDX_W  frame width (pixels), sampled only on accepted SOF beat
CfgHeight  in  IMG_HEIGHT_IDX_W  frame height (lines), sampled only on accepted SOF beat
SrcData  in  PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W  packed pixel, component i at [i*W +: W]
SrcSof  in  1  beat is first pixel of a frame
SrcEol  in  1  beat is last pixel of a line
SrcVld  in  1  source beat valid
SrcRdy  out  1  block can accept a beat
PxlData  out  PXL_PRIM_COLOR_NUM x PXL_PRIM_COLOR_W  unpacked array to resizer
PxlX  out  IMG_WIDTH_IDX_W  pixel column
PxlY  out  IMG_HEIGHT_IDX_W  pixel row
ImgWidth  out  IMG_WIDTH_IDX_W  latched frame width
ImgHeight  out  IMG_HEIGHT_IDX_W  latched frame height
PxlVld  out  1  output pixel valid
PxlRdy  in  1  resizer ready
FrmDone  out  1  1-cycle pulse on output handshake of last pixel of a frame
ErrSof  out  1  1-cycle pulse: SOF missing or early
ErrEol  out  1  1-cycle pulse: EOL marker mismatch
ErrCfg  out  1  1-cycle pulse: SOF with zero width or height

Behaviour:
- Reset (sync, high): all outputs 0, skid buffer empty, state IDLE. A reset mid-frame discards buffered pixels without emitting them. SrcRdy=0 while Reset=1. SrcRdy=1 in the first cycle after deassertion.
- Handshakes: transfer occurs when Vld&Rdy at the rising edge. PxlVld is never retracted, and PxlData/X/Y/ImgWidth/ImgHeight are held stable while PxlVld&!PxlRdy.
- Skid buffer: 2 entries. SrcRdy is a registered signal equal to (occupancy < 2 after this cycle's updates), so it is not combinationally dependent on PxlRdy. Latency is 1 cycle from source accept to PxlVld. Throughput is 1 pixel/cycle with PxlRdy held high.
- Each entry stores data, X, Y, ImgWidth, ImgHeight and a last-of-frame flag.
- State IDLE:
  - Accepted beat with SrcSof=0: dropped, ErrSof pulse.
  - Accepted beat with SrcSof=1 and CfgWidth==0 or CfgHeight==0: dropped, ErrCfg pulse, stay IDLE.
  - Otherwise: latch CfgWidth/CfgHeight, enqueue pixel (X=0,Y=0), go ACTIVE.
- State ACTIVE: each accepted beat is tagged (Xcnt,Ycnt).
  - If Xcnt==W-1: Xcnt<=0, Ycnt<=Ycnt+1. Else Xcnt<=Xcnt+1.
  - EOL check: expected = (Xcnt==W-1). SrcEol!=expected gives an ErrEol pulse. The pixel is still forwarded, and coordinates always follow the counters, never the markers.
  - Last pixel (Xcnt==W-1 && Ycnt==H-1): enqueued with last flag, go IDLE.
  - Accepted beat with SrcSof=1 in ACTIVE: ErrSof pulse. The current frame is abandoned without FrmDone, already-buffered pixels are still emitted, and the beat starts a new frame exactly as in IDLE (re-latch config, X=0,Y=0). If that config is zero, ErrCfg is pulsed and the state goes to IDLE.
- A 1x1 frame: SOF beat is also last; SrcEol=1 is expected; go straight back to IDLE.
- Config changes while ACTIVE are ignored until the next SOF.
- FrmDone pulses in the cycle after the output handshake of the flagged last pixel.
- Error pulses are asserted the cycle after the offending source handshake. Multiple errors on one beat assert together.
- Counter arithmetic is unsigned and never exceeds W-1 / H-1.

Test Plan:
1. CfgWidth=4, CfgHeight=2, 8 beats with SOF on beat 0 and EOL on beats 3,7, PxlRdy=1 -> outputs (0,0)..(3,0),(0,1)..(3,1), ImgWidth=4, ImgHeight=2, one FrmDone, no errors, 8 consecutive PxlVld cycles.
2. Same frame with PxlRdy toggling 1-0-0-1 pseudo-randomly and 0-2 cycle source bubbles -> identical ordered output, no data change while stalled, SrcRdy drops only when 2 entries are held.
3. W=129, H=65, SOF re-asserted at pixel (5,3) -> ErrSof pulse once, earlier pixels emitted, new frame restarts at (0,0), completes 8385 pixels, exactly one FrmDone.
4. W=4, H=2, EOL on beat 2 instead of 3 -> ErrEol pulses for beats 2 and 3, coordinates unchanged from scenario 1, FrmDone still asserted.
5. CfgWidth=1, CfgHeight=1, single SOF+EOL beat -> one pixel (0,0), FrmDone; then beat without SOF -> dropped, ErrSof, no PxlVld.
6. Reset asserted mid-frame with 2 entries buffered -> PxlVld=0 next cycle, no FrmDone; SOF with CfgHeight=0 afterwards -> ErrCfg, dropped.
